axi_read_burst_sequencer: RTL and testbench
===========================================

Name: axi_read_burst_sequencer

Overview:
- AXI4 read-master sequencer driven by the CSR block's read_base_address, read_burst_count, read_burst_len, single_read_trigger and loop_read_enable.
- Issues cfg_burst_count INCR bursts of cfg_burst_len beats from consecutive addresses and keeps at most MAX_OUTSTANDING bursts in flight.
- Forwards read data to an AXI-Stream output and reports busy, done and a sticky error status back to the CSR block.

Parameters:
- ADDR_WIDTH, 48: AXI address width.
- DATA_WIDTH, 128: AXI/stream data width; bytes per beat BPB = DATA_WIDTH/8.
- MAX_OUTSTANDING, 4: maximum accepted-but-incomplete bursts, range 1..15.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- cfg_base_address  in  ADDR_WIDTH  start byte address, BPB-aligned
- cfg_burst_count  in  32  number of bursts per run
- cfg_burst_len  in  9  beats per burst
- start  in  1  single-run trigger, sampled in IDLE
- loop_enable  in  1  automatic restart after each run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- error  out  1  sticky: some rresp != OKAY in current/last run
- m_axi_araddr  out  ADDR_WIDTH
- m_axi_arlen  out  8
- m_axi_arsize  out  3  constant log2(BPB)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axis_tdata  out  DATA_WIDTH
- m_axis_tlast  out  1
- m_axis_tvalid  out  1
- m_axis_tready  in  1

Behaviour:
- Reset (async assert, deassert synchronous to aclk): state IDLE; busy, done, error, arvalid = 0; araddr, arlen = 0; outstanding count = 0.
- States:
  - IDLE: start=1 or loop_enable=1 causes the run to be latched.
  - ISSUE: runs until the last AR handshake.
  - DRAIN: runs until outstanding == 0, then emits the done pulse.
- Run latch, taken in IDLE: base, count and eff_len are captured; error is cleared.
  - eff_len = 1 if cfg_burst_len == 0; 256 if cfg_burst_len > 256; otherwise cfg_burst_len.
  - Config changes after the latch have no effect until the next run.
- Latched count == 0: no AR is issued; done pulses the next cycle; busy stays 0; state returns to IDLE.
- Timing:
  - busy = 1 from the cycle after the latch through the cycle done is asserted.
  - First arvalid is asserted the cycle after the latch.
- AR channel:
  - m_axi_arlen = eff_len - 1.
  - Once arvalid = 1, araddr and arlen are held stable until arready.
  - arvalid may only rise when outstanding < MAX_OUTSTANDING.
  - After each AR handshake: araddr += eff_len*BPB, modulo 2^ADDR_WIDTH; remaining count -= 1.
  - Back-to-back AR issue (one per cycle) is allowed while credit remains.
  - Address wrap and 4 KB crossings are not checked; software keeps bursts inside 4 KB.
- Outstanding counter:
  - +1 on AR handshake; -1 on R handshake with rlast = 1.
  - Both in the same cycle: counter unchanged.
- R channel: combinational pass-through.
  - m_axis_tdata = rdata, m_axis_tvalid = rvalid, m_axis_tlast = rlast, m_axi_rready = m_axis_tready.
  - Data is forwarded in any state.
- Error: set on any R handshake with rresp != 2'b00; cleared only at the next run latch.
- done: asserted for one cycle after the last AR handshake once outstanding reaches 0.
- Loop: if loop_enable = 1 in the done cycle, the next run is latched in the following IDLE cycle with the current config.
  - Minimum gap between runs is 1 IDLE cycle.
  - Clearing loop_enable mid-run finishes the current run, then stays in IDLE.
- Triggers while busy: start is ignored (not queued).
- Reset mid-run: all state is abandoned immediately; in-flight AXI transactions must be flushed by resetting the interconnect together with this block.

Test Plan:
1. Base 0x1000_0000, count 8, len 16, arready and tready always 1, single start:
   - 8 ARs at 0x1000_0000 + k*0x100, arlen = 15;
   - 128 stream beats with tlast every 16th beat;
   - done pulses once; busy falls the cycle after done.
2. MAX_OUTSTANDING = 4, count 10, len 4, rvalid withheld:
   - exactly 4 AR handshakes, then arvalid stays 0;
   - releasing one full burst allows exactly one more AR.
3. Count 0:
   - no arvalid; done pulses 1 cycle after start; busy stays 0.
4. Boundary cases:
   - cfg_burst_len = 0 -> arlen = 0, address step 16;
   - cfg_burst_len = 300 -> arlen = 255, step 0x1000;
   - random arready stalls -> araddr/arlen stable while arvalid = 1.
5. Burst 3 of 5 returns rresp = SLVERR:
   - error = 1 until the next start, and is cleared on that latch;
   - loop_enable = 1 with count 2 -> runs repeat, each separated by one IDLE cycle;
   - deassert loop_enable -> current run completes, block stays IDLE.
6. Assert areset during ISSUE with 2 outstanding:
   - arvalid, busy and done go 0 immediately (asynchronously);
   - after release, a new start begins from the newly latched base.

Source files
------------

// File: rtl/axi_read_burst_sequencer_if.sv
// AXI4 read-address/read-data channels plus the AXI-Stream output of the burst sequencer.
// master = sequencer side, slave = memory/stream-sink side.
interface axi_read_burst_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axi_read_burst_sequencer.sv
// AXI4 read-master: issues a configured number of INCR bursts with bounded outstanding
// bursts and forwards the read data straight onto an AXI-Stream output.
module axi_read_burst_sequencer #(
    parameter int unsigned ADDR_WIDTH      = 48,
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] cfg_base_address,
    input  logic [31:0]           cfg_burst_count,
    input  logic [8:0]            cfg_burst_len,
    input  logic                  start,
    input  logic                  loop_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    axi_read_burst_sequencer_if.master bus
);

    localparam int unsigned Bpb     = DATA_WIDTH / 8;
    localparam int unsigned SizeLog = $clog2(Bpb);
    localparam int unsigned CntW    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic                  arvalid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [ADDR_WIDTH-1:0] step_q;
    logic [31:0]           rem_q;
    logic [CntW-1:0]       out_q;
    logic [CntW-1:0]       out_d;

    logic       ar_hs;
    logic       r_hs;
    logic       burst_end;
    logic [8:0] eff_len;

    assign ar_hs     = arvalid_q & bus.m_axi_arready;
    assign r_hs      = bus.m_axi_rvalid & bus.m_axis_tready;
    assign burst_end = r_hs & bus.m_axi_rlast & (out_q != '0);

    always_comb begin
        if (cfg_burst_len == 9'd0) begin
            eff_len = 9'd1;
        end else if (cfg_burst_len > 9'd256) begin
            eff_len = 9'd256;
        end else begin
            eff_len = cfg_burst_len;
        end
    end

    always_comb begin
        out_d = out_q;
        if (ar_hs && !burst_end) begin
            out_d = out_q + 1'b1;
        end else if (!ar_hs && burst_end) begin
            out_d = out_q - 1'b1;
        end
    end

    // Read data is never buffered: the stream sink back-pressures the R channel directly.
    assign bus.m_axis_tdata  = bus.m_axi_rdata;
    assign bus.m_axis_tvalid = bus.m_axi_rvalid;
    assign bus.m_axis_tlast  = bus.m_axi_rlast;
    assign bus.m_axi_rready  = bus.m_axis_tready;

    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = 3'(SizeLog);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid_q;

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            step_q    <= '0;
            rem_q     <= '0;
            out_q     <= '0;
        end else begin
            out_q <= out_d;
            if (r_hs && (bus.m_axi_rresp != 2'b00)) begin
                error_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start || loop_enable) begin
                        error_q  <= 1'b0;
                        araddr_q <= cfg_base_address;
                        arlen_q  <= 8'(eff_len - 9'd1);
                        step_q   <= ADDR_WIDTH'(eff_len) << SizeLog;
                        rem_q    <= cfg_burst_count;
                        if (cfg_burst_count == 32'd0) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            busy_q    <= 1'b1;
                            arvalid_q <= (out_d < CntW'(MAX_OUTSTANDING));
                            state_q   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (ar_hs) begin
                        araddr_q <= araddr_q + step_q;
                        rem_q    <= rem_q - 32'd1;
                    end
                    // Credit uses the next-cycle count, so a raised arvalid never needs to drop.
                    if (ar_hs && (rem_q == 32'd1)) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StDrain;
                    end else begin
                        arvalid_q <= (out_d < CntW'(MAX_OUTSTANDING));
                    end
                end
                StDrain: begin
                    if (out_d == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    ap_out_bound: assert property (@(posedge aclk) disable iff (areset)
        out_q <= CntW'(MAX_OUTSTANDING));

    ap_ar_stable: assert property (@(posedge aclk) disable iff (areset)
        (arvalid_q && !bus.m_axi_arready) |=>
            (arvalid_q && $stable(araddr_q) && $stable(arlen_q)));

endmodule

// File: tb/tb_axi_read_burst_sequencer.sv
// Directed bench for axi_read_burst_sequencer: an AXI read slave model feeds the DUT and a
// monitor logs AR requests and stream beats; each test task checks its own scenario.
module tb_axi_read_burst_sequencer;

    localparam int AW  = 48;
    localparam int DW  = 128;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          areset;
    logic [AW-1:0] cfg_base_address;
    logic [31:0]   cfg_burst_count;
    logic [8:0]    cfg_burst_len;
    logic          start;
    logic          loop_enable;
    logic          busy;
    logic          done;
    logic          error;

    axi_read_burst_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_read_burst_sequencer #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (4)
    ) dut (
        .aclk             (clk),
        .areset           (areset),
        .cfg_base_address (cfg_base_address),
        .cfg_burst_count  (cfg_burst_count),
        .cfg_burst_len    (cfg_burst_len),
        .start            (start),
        .loop_enable      (loop_enable),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] aq[$];
    logic [7:0]    lq[$];
    int            rq[$];
    bit            sq[$];
    int            ar_count, beats, done_count, pt_bad, stab_bad;
    int            sl_served, sl_err_burst, sl_ar_budget, sl_r_budget;
    bit            sl_ar_rand;
    bit            r_active;
    int            r_len, r_beat;
    logic [1:0]    r_resp;
    bit            st_pend;
    logic [AW-1:0] st_addr;
    logic [7:0]    st_len;

    // Slave model drives at +1 after the edge and observes handshakes at +2.
    initial begin
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_axi_arready = (sl_ar_budget > 0) && (!sl_ar_rand || ($urandom_range(0, 1) == 1));
            if (!r_active && (rq.size() > 0) && (sl_r_budget > 0)) begin
                r_len = rq.pop_front();
                r_beat = 0;
                r_active = 1'b1;
                sl_r_budget--;
                r_resp = (sl_served == sl_err_burst) ? 2'b10 : 2'b00;
            end
            bus.m_axi_rvalid = r_active;
            bus.m_axi_rdata  = {32'(sl_served), 32'hA5A5_0000, 32'(r_beat), 32'h5A};
            bus.m_axi_rlast  = r_active && (r_beat == r_len - 1);
            bus.m_axi_rresp  = r_active ? r_resp : 2'b00;
            #1;
            if ((bus.m_axis_tdata !== bus.m_axi_rdata) || (bus.m_axis_tvalid !== bus.m_axi_rvalid) ||
                (bus.m_axis_tlast !== bus.m_axi_rlast) || (bus.m_axi_rready !== bus.m_axis_tready))
                pt_bad++;
            if (st_pend && ((bus.m_axi_arvalid !== 1'b1) || (bus.m_axi_araddr !== st_addr) ||
                            (bus.m_axi_arlen !== st_len)))
                stab_bad++;
            st_pend = bus.m_axi_arvalid && !bus.m_axi_arready;
            st_addr = bus.m_axi_araddr;
            st_len  = bus.m_axi_arlen;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                aq.push_back(bus.m_axi_araddr);
                lq.push_back(bus.m_axi_arlen);
                rq.push_back(int'(bus.m_axi_arlen) + 1);
                ar_count++;
                sl_ar_budget--;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                beats++;
                sq.push_back(bus.m_axis_tlast);
                if (bus.m_axi_rlast) begin
                    r_active = 1'b0;
                    sl_served++;
                end else begin
                    r_beat++;
                end
            end
            if (done === 1'b1) done_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_logs();
        aq.delete();
        lq.delete();
        sq.delete();
        ar_count = 0;
        beats = 0;
        done_count = 0;
        sl_served = 0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic launch(input logic [AW-1:0] base, input int count, input int len);
        cfg_base_address = base;
        cfg_burst_count  = 32'(count);
        cfg_burst_len    = 9'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        start = 1'b0;
        loop_enable = 1'b0;
        cfg_base_address = '0;
        cfg_burst_count = '0;
        cfg_burst_len = '0;
        sl_ar_budget = BIG;
        sl_r_budget = BIG;
        sl_err_burst = -1;
        sl_ar_rand = 1'b0;
        clear_logs();
        repeat (3) tick();
        n_checks++;
        if ({busy, done, error, bus.m_axi_arvalid} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, error, bus.m_axi_arvalid});
        end
        n_checks++;
        if (bus.m_axi_araddr !== '0 || bus.m_axi_arlen !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_ar got %h/%h want 0/0", bus.m_axi_araddr, bus.m_axi_arlen);
        end
        n_checks++;
        if (bus.m_axi_arsize !== 3'd4 || bus.m_axi_arburst !== 2'b01) begin
            n_errors++;
            $display("FAIL ar_const got %0d/%b want 4/01", bus.m_axi_arsize, bus.m_axi_arburst);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        bit seen;
        int tl_bad;
        logic [AW-1:0] got;
        clear_logs();
        launch(48'h1000_0000, 8, 16);
        n_checks++;
        if (busy !== 1'b1 || bus.m_axi_arvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL first_ar got busy=%b arvalid=%b want 1/1", busy, bus.m_axi_arvalid);
        end
        wait_done(2000, seen);
        n_checks++;
        if (!seen || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_done got seen=%b busy=%b want 1/1", seen, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_busy_fall got busy=%b done=%b want 0/0", busy, done);
        end
        tick();
        n_checks++;
        if (ar_count != 8 || done_count != 1) begin
            n_errors++;
            $display("FAIL basic_counts got ar=%0d done=%0d want 8/1", ar_count, done_count);
        end
        for (int k = 0; k < 8; k++) begin
            got = (k < aq.size()) ? aq[k] : '1;
            n_checks++;
            if (got !== 48'h1000_0000 + 48'(k) * 48'h100 || (k < lq.size() && lq[k] !== 8'd15)) begin
                n_errors++;
                $display("FAIL basic_ar%0d got %h want %h len 15", k, got,
                         48'h1000_0000 + 48'(k) * 48'h100);
            end
        end
        tl_bad = 0;
        foreach (sq[i]) if (sq[i] != ((i % 16) == 15)) tl_bad++;
        n_checks++;
        if (beats != 128 || tl_bad != 0) begin
            n_errors++;
            $display("FAIL basic_stream got beats=%0d tlast_bad=%0d want 128/0", beats, tl_bad);
        end
    endtask

    task automatic test_outstanding_limit();
        bit seen;
        clear_logs();
        sl_r_budget = 0;
        launch(48'h2000_0000, 10, 4);
        repeat (20) tick();
        n_checks++;
        if (ar_count != 4 || bus.m_axi_arvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL limit_four got ar=%0d arvalid=%b want 4/0", ar_count, bus.m_axi_arvalid);
        end
        sl_r_budget = 1;
        repeat (20) tick();
        n_checks++;
        if (ar_count != 5 || beats != 4 || bus.m_axi_arvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL limit_release got ar=%0d beats=%0d arvalid=%b want 5/4/0",
                     ar_count, beats, bus.m_axi_arvalid);
        end
        sl_r_budget = BIG;
        wait_done(2000, seen);
        tick();
        n_checks++;
        if (!seen || ar_count != 10 || beats != 40) begin
            n_errors++;
            $display("FAIL limit_finish got seen=%b ar=%0d beats=%0d want 1/10/40",
                     seen, ar_count, beats);
        end
    endtask

    task automatic test_zero_count();
        clear_logs();
        launch(48'h3000, 0, 4);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.m_axi_arvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_done got done=%b busy=%b arvalid=%b want 1/0/0",
                     done, busy, bus.m_axi_arvalid);
        end
        repeat (5) tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ar_count != 0 || done_count != 1) begin
            n_errors++;
            $display("FAIL zero_after got done=%b busy=%b ar=%0d pulses=%0d want 0/0/0/1",
                     done, busy, ar_count, done_count);
        end
    endtask

    task automatic test_len_boundaries();
        bit seen;
        logic [AW-1:0] got;
        clear_logs();
        launch(48'h2000, 3, 0);
        wait_done(500, seen);
        tick();
        for (int k = 0; k < 3; k++) begin
            got = (k < aq.size()) ? aq[k] : '1;
            n_checks++;
            if (got !== 48'h2000 + 48'(k) * 48'h10 || (k < lq.size() && lq[k] !== 8'd0)) begin
                n_errors++;
                $display("FAIL len0_ar%0d got %h want %h len 0", k, got, 48'h2000 + 48'(k) * 48'h10);
            end
        end
        clear_logs();
        launch(48'h4000_0000, 2, 300);
        wait_done(3000, seen);
        tick();
        got = (aq.size() > 1) ? aq[1] : '1;
        n_checks++;
        if (!seen || got !== 48'h4000_1000 || lq.size() != 2 || lq[0] !== 8'd255 || beats != 512) begin
            n_errors++;
            $display("FAIL len300 got addr1=%h beats=%0d want 4000_1000/512 len 255", got, beats);
        end
    endtask

    task automatic test_arready_stalls();
        bit seen;
        logic [AW-1:0] got;
        clear_logs();
        sl_ar_rand = 1'b1;
        launch(48'h8000, 6, 8);
        wait_done(2000, seen);
        tick();
        sl_ar_rand = 1'b0;
        got = (aq.size() > 5) ? aq[5] : '1;
        n_checks++;
        if (!seen || ar_count != 6 || got !== 48'h8280) begin
            n_errors++;
            $display("FAIL stall_run got seen=%b ar=%0d addr5=%h want 1/6/8280", seen, ar_count, got);
        end
        n_checks++;
        if (stab_bad != 0) begin
            n_errors++;
            $display("FAIL ar_stable got %0d unstable cycles want 0", stab_bad);
        end
    endtask

    task automatic test_error_and_loop();
        bit seen;
        int ar_snap;
        clear_logs();
        sl_err_burst = 2;
        launch(48'h6000, 5, 2);
        wait_done(1000, seen);
        n_checks++;
        if (!seen || error !== 1'b1) begin
            n_errors++;
            $display("FAIL err_set got seen=%b error=%b want 1/1", seen, error);
        end
        repeat (5) tick();
        n_checks++;
        if (error !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky got %b want 1", error);
        end
        sl_err_burst = -1;
        clear_logs();
        launch(48'h6000, 1, 2);
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL err_clear got error=%b busy=%b want 0/1", error, busy);
        end
        wait_done(500, seen);
        tick();
        clear_logs();
        cfg_burst_count = 32'd2;
        loop_enable = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            wait_done(500, seen);
            tick();
            n_checks++;
            if (!seen || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL loop_gap%0d got seen=%b busy=%b want 1/0", r, seen, busy);
            end
            tick();
            n_checks++;
            if (busy !== 1'b1) begin
                n_errors++;
                $display("FAIL loop_restart%0d got busy=%b want 1", r, busy);
            end
        end
        loop_enable = 1'b0;
        wait_done(500, seen);
        tick();
        ar_snap = ar_count;
        repeat (10) tick();
        n_checks++;
        if (!seen || busy !== 1'b0 || ar_snap != 6 || ar_count != 6 || done_count != 3) begin
            n_errors++;
            $display("FAIL loop_stop got busy=%b ar=%0d/%0d dones=%0d want 0/6/6/3",
                     busy, ar_snap, ar_count, done_count);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        logic [AW-1:0] got0, got1;
        clear_logs();
        sl_ar_budget = 2;
        sl_r_budget = 0;
        launch(48'h3000_0000, 10, 4);
        repeat (10) tick();
        n_checks++;
        if (ar_count != 2 || busy !== 1'b1 || bus.m_axi_arvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset got ar=%0d busy=%b arvalid=%b want 2/1/1",
                     ar_count, busy, bus.m_axi_arvalid);
        end
        areset = 1'b1;
        #1;
        n_checks++;
        if (bus.m_axi_arvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset got arvalid=%b busy=%b done=%b want 0/0/0",
                     bus.m_axi_arvalid, busy, done);
        end
        rq.delete();
        r_active = 1'b0;
        st_pend = 1'b0;
        sl_ar_budget = BIG;
        sl_r_budget = BIG;
        repeat (2) tick();
        areset = 1'b0;
        tick();
        clear_logs();
        launch(48'h5000_0000, 2, 4);
        wait_done(500, seen);
        tick();
        got0 = (aq.size() > 0) ? aq[0] : '1;
        got1 = (aq.size() > 1) ? aq[1] : '1;
        n_checks++;
        if (!seen || ar_count != 2 || got0 !== 48'h5000_0000 || got1 !== 48'h5000_0040 || beats != 8) begin
            n_errors++;
            $display("FAIL post_reset got ar=%0d a0=%h a1=%h beats=%0d want 2/5000_0000/5000_0040/8",
                     ar_count, got0, got1, beats);
        end
        n_checks++;
        if (pt_bad != 0) begin
            n_errors++;
            $display("FAIL passthrough got %0d bad cycles want 0", pt_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_outstanding_limit();
        test_zero_count();
        test_len_boundaries();
        test_arready_stalls();
        test_error_and_loop();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
